// File: rtl/mnet_sdram_pkg.sv
// Shared SDRAM types and default widths for the port arbiter,
// the write-back controller and the fetch controllers.
package mnet_sdram_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping around, as a one-hot winner plus its index.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   c;
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        c      = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && req[c]) begin
                found     = 1'b1;
                winner[c] = 1'b1;
                idx       = IW'(c);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM command port between masters,
// with bounded bursts per grantee and a watchdog on controller ready.
module sdram_port_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = mnet_sdram_pkg::ADDR_W,
    parameter int DATA_W    = mnet_sdram_pkg::DATA_W,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_err,
    output logic                      o_timeoutSticky,
    output logic [ADDR_W-1:0]         o_addrToSdram,
    output logic                      o_wrSdram,
    output logic                      o_rdSdram,
    output logic [DATA_W-1:0]         o_wdataToSdram,
    input  logic                      i_sdramReady,
    input  logic [DATA_W-1:0]         i_rdataSdram
);

    import mnet_sdram_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int BC_W  = $clog2(BURST_MAX + 1);

    arb_state_t state_q, state_d;

    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   last_q;
    logic [BC_W-1:0]    burst_q;
    logic [WD_W-1:0]    wd_q;

    logic [NUM_REQ-1:0] last_oh;
    logic [NUM_REQ-1:0] others_req;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] sel_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   rr_next;
    logic               cont;
    logic               ready_hit;
    logic               tmo_hit;

    // Leaving a burst, skip the previous grantee unless it is the only requester.
    assign last_oh    = NUM_REQ'(1) << last_q;
    assign others_req = i_req & ~last_oh;
    assign pick_req   = (|others_req) ? others_req : i_req;
    assign cont       = i_req[last_q] && (burst_q < BC_W'(BURST_MAX));
    assign sel_idx    = cont ? last_q : pick_idx;
    assign sel_oh     = cont ? last_oh : pick_oh;
    assign rr_next    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : pick_idx + IDX_W'(1);

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_picker (
        .req    (pick_req),
        .ptr    (rr_ptr_q),
        .winner (pick_oh),
        .idx    (pick_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ready_hit = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|i_req) state_d = ACCESS;
            end
            ACCESS: begin
                if (i_sdramReady) begin
                    ready_hit = 1'b1;
                    state_d   = DONE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr_q        <= '0;
            last_q          <= '0;
            burst_q         <= '0;
            wd_q            <= '0;
            o_gnt           <= '0;
            o_done          <= '0;
            o_rdata         <= '0;
            o_err           <= 1'b0;
            o_timeoutSticky <= 1'b0;
            o_addrToSdram   <= '0;
            o_wrSdram       <= 1'b0;
            o_rdSdram       <= 1'b0;
            o_wdataToSdram  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|i_req) begin
                        o_addrToSdram  <= i_addr[sel_idx*ADDR_W +: ADDR_W];
                        o_wdataToSdram <= i_wdata[sel_idx*DATA_W +: DATA_W];
                        o_wrSdram      <= i_wr[sel_idx];
                        o_rdSdram      <= ~i_wr[sel_idx];
                        o_gnt          <= sel_oh;
                        o_err          <= 1'b0;
                        wd_q           <= '0;
                        last_q         <= sel_idx;
                        if (!cont) begin
                            rr_ptr_q <= rr_next;
                            burst_q  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (ready_hit) begin
                        o_wrSdram <= 1'b0;
                        o_rdSdram <= 1'b0;
                        if (o_rdSdram) o_rdata <= i_rdataSdram;
                        burst_q   <= burst_q + BC_W'(1);
                        o_done    <= o_gnt;
                    end else if (tmo_hit) begin
                        o_wrSdram       <= 1'b0;
                        o_rdSdram       <= 1'b0;
                        o_err           <= 1'b1;
                        o_timeoutSticky <= 1'b1;
                        burst_q         <= BC_W'(BURST_MAX);
                        o_done          <= o_gnt;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                DONE: begin
                    o_done <= '0;
                    o_gnt  <= '0;
                    o_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomised bench for sdram_port_arbiter: transaction-level reference
// model checked every cycle, plus directed scenarios with literal results.
module tb_sdram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BM = 4;
    localparam int TO = 8;
    localparam int VW = 2*N + 2*DW + AW + 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, wr;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic              ready;
    logic [DW-1:0]     rdata_sdram;
    logic [N-1:0]      o_gnt, o_done;
    logic [DW-1:0]     o_rdata, o_wdataToSdram;
    logic              o_err, o_timeoutSticky, o_wrSdram, o_rdSdram;
    logic [AW-1:0]     o_addrToSdram;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_MAX (BM),
        .TIMEOUT   (TO)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_req           (req),
        .i_wr            (wr),
        .i_addr          (addr),
        .i_wdata         (wdata),
        .o_gnt           (o_gnt),
        .o_done          (o_done),
        .o_rdata         (o_rdata),
        .o_err           (o_err),
        .o_timeoutSticky (o_timeoutSticky),
        .o_addrToSdram   (o_addrToSdram),
        .o_wrSdram       (o_wrSdram),
        .o_rdSdram       (o_rdSdram),
        .o_wdataToSdram  (o_wdataToSdram),
        .i_sdramReady    (ready),
        .i_rdataSdram    (rdata_sdram)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    int          shots [N];
    int          delay_mode = 0;
    int          starve = 0;
    int          p_raise = 100;
    bit          noise = 0;
    bit          mid_drop = 0;
    bit          use_fix = 0;
    logic [AW-1:0] fix_addr [N];
    logic [DW-1:0] fix_wdata [N];
    logic          fix_wr [N];
    logic [DW-1:0] rd_val = '0;

    // observation logs
    int          gq [$];
    int          done_t [$];
    int          cmd_cycles, wr_cycles, rd_cycles, err_cnt, cyc;
    logic [N-1:0] done_val, prev_gnt;
    logic [DW-1:0] rdata_at_done;
    logic [AW-1:0] cmd_addr;
    int          acc_cyc, delay;

    // reference model state
    int          m_phase, m_owner, m_run, m_ptr, m_wait;
    bit          chk_en = 0;
    logic [N-1:0]  e_gnt, e_done;
    logic [DW-1:0] e_rdata, e_wdata;
    logic          e_err, e_sticky, e_wr, e_rd;
    logic [AW-1:0] e_addr;

    function automatic int oh2i(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            chk_en = 1;
            m_phase = 0; m_owner = 0; m_run = 0; m_ptr = 0; m_wait = 0;
            e_gnt = '0; e_done = '0; e_rdata = '0; e_err = 0; e_sticky = 0;
            e_addr = '0; e_wr = 0; e_rd = 0; e_wdata = '0;
        end else if (m_phase == 0) begin
            if (|req) begin
                int w;
                w = -1;
                if (req[m_owner] && m_run < BM) begin
                    w = m_owner;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        int c;
                        c = (m_ptr + i) % N;
                        if (w < 0 && req[c] && c != m_owner) w = c;
                    end
                    if (w < 0) w = m_owner;
                    m_ptr = (w + 1) % N;
                    m_run = 0;
                end
                m_owner = w;
                e_gnt   = N'(1) << w;
                e_addr  = addr[w*AW +: AW];
                e_wdata = wdata[w*DW +: DW];
                e_wr    = wr[w];
                e_rd    = !wr[w];
                e_err   = 0;
                m_wait  = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_wait++;
            if (ready) begin
                if (e_rd) e_rdata = rdata_sdram;
                e_wr = 0; e_rd = 0;
                e_done = e_gnt;
                m_run++;
                m_phase = 2;
            end else if (m_wait >= TO) begin
                e_wr = 0; e_rd = 0;
                e_err = 1; e_sticky = 1;
                e_done = e_gnt;
                m_run = BM;
                m_phase = 2;
            end
        end else begin
            e_done = '0; e_gnt = '0; e_err = 0;
            m_phase = 0;
        end
    end

    task automatic new_ops(int k);
        if (use_fix) begin
            addr[k*AW +: AW]  = fix_addr[k];
            wdata[k*DW +: DW] = fix_wdata[k];
            wr[k]             = fix_wr[k];
        end else begin
            addr[k*AW +: AW]  = AW'($urandom);
            wdata[k*DW +: DW] = DW'($urandom);
            wr[k]             = 1'($urandom);
        end
    endtask

    // compare, log, then drive next-cycle inputs
    always @(negedge clk) begin
        logic [VW-1:0] got, exp;
        got = {o_gnt, o_done, o_rdata, o_err, o_timeoutSticky,
               o_addrToSdram, o_wrSdram, o_rdSdram, o_wdataToSdram};
        exp = {e_gnt, e_done, e_rdata, e_err, e_sticky,
               e_addr, e_wr, e_rd, e_wdata};
        if (chk_en) begin
            checks++;
            if (got !== exp) begin
                errors++;
                if (errors <= 10)
                    $display("FAIL cycle_cmp @%0d: got %h, expected %h", cyc, got, exp);
            end
        end

        if (o_gnt != 0 && prev_gnt == 0) gq.push_back(oh2i(o_gnt));
        if (o_done != 0) begin
            done_t.push_back(cyc);
            done_val = o_done;
            rdata_at_done = o_rdata;
            if (o_err) err_cnt++;
        end
        if (o_wrSdram | o_rdSdram) begin
            cmd_cycles++;
            cmd_addr = o_addrToSdram;
        end
        if (o_wrSdram) wr_cycles++;
        if (o_rdSdram) rd_cycles++;
        prev_gnt = o_gnt;
        cyc++;

        if (o_wrSdram | o_rdSdram) begin
            acc_cyc++;
            if (acc_cyc == 1) begin
                if (starve > 0) begin
                    delay = 0;
                    starve--;
                end else begin
                    delay = (delay_mode > 0) ? delay_mode : $urandom_range(1, 4);
                end
            end
            ready = (delay != 0 && acc_cyc == delay);
            rdata_sdram = (ready && use_fix) ? rd_val : DW'($urandom);
        end else begin
            acc_cyc = 0;
            ready = noise ? 1'($urandom) : 1'b0;
            rdata_sdram = DW'($urandom);
        end

        for (int k = 0; k < N; k++) begin
            if (o_done[k]) begin
                shots[k]--;
                if (shots[k] <= 0) begin
                    req[k] = 1'b0;
                end else begin
                    req[k] = 1'b1;
                    new_ops(k);
                end
            end else if (!req[k] && !o_gnt[k]) begin
                if (shots[k] > 0 && $urandom_range(1, 100) <= p_raise) begin
                    req[k] = 1'b1;
                    new_ops(k);
                end else if (!use_fix) begin
                    new_ops(k);
                end
            end else if (req[k] && mid_drop && o_gnt[k] && $urandom_range(0, 7) == 0) begin
                req[k] = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        gq.delete();
        done_t.delete();
        cmd_cycles = 0; wr_cycles = 0; rd_cycles = 0; err_cnt = 0;
        done_val = '0; rdata_at_done = '0; cmd_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        req = '0;
        for (int k = 0; k < N; k++) shots[k] = 0;
        starve = 0; noise = 0; mid_drop = 0; use_fix = 0;
        delay_mode = 0; p_raise = 100;
        @(negedge clk); #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seq [13];
        seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
        ready = 1'b0; rdata_sdram = '0; cyc = 0; acc_cyc = 0; delay = 0;
        prev_gnt = '0;
        for (int k = 0; k < N; k++) begin
            shots[k] = 0; fix_addr[k] = '0; fix_wdata[k] = '0; fix_wr[k] = 1'b0;
        end
        clear_logs();
        do_reset();
        check("reset_gnt", o_gnt, 0);
        check("reset_cmd", {o_wrSdram, o_rdSdram}, 0);
        check("reset_sticky", o_timeoutSticky, 0);

        // single write, ready in the 2nd command cycle
        use_fix = 1; fix_addr[0] = 19'd10000; fix_wdata[0] = 16'hA5A5; fix_wr[0] = 1'b1;
        delay_mode = 2; shots[0] = 1;
        cycles(12);
        check("wr_cmd_cycles", wr_cycles, 2);
        check("wr_addr", cmd_addr, 10000);
        check("wr_done_val", done_val, 1);
        check("wr_done_count", done_t.size(), 1);
        check("wr_err", err_cnt, 0);

        // contention burst order
        do_reset();
        for (int k = 0; k < N; k++) shots[k] = 100;
        for (int t = 0; t < 300 && gq.size() < 13; t++) cycles(1);
        check("cont_grants", gq.size() >= 13, 1);
        for (int i = 0; i < 13; i++)
            if (i < gq.size()) check($sformatf("cont_gnt%0d", i), gq[i], seq[i]);

        // read by master 1
        do_reset();
        use_fix = 1; fix_addr[1] = 19'd20000; fix_wr[1] = 1'b0; rd_val = 16'h1234;
        delay_mode = 3; shots[1] = 1;
        cycles(12);
        check("rd_done_val", done_val, 2);
        check("rd_rdata", rdata_at_done, 16'h1234);
        check("rd_cycles", rd_cycles, 3);
        check("rd_no_wr", wr_cycles, 0);
        check("rd_addr", cmd_addr, 20000);

        // timeout, then another master proceeds
        do_reset();
        starve = 1; delay_mode = 1; shots[0] = 1; shots[1] = 1;
        cycles(25);
        check("to_cmd_cycles", cmd_cycles, TO + 1);
        check("to_err_count", err_cnt, 1);
        check("to_sticky", o_timeoutSticky, 1);
        check("to_dones", done_t.size(), 2);
        check("to_order", (gq.size() == 2) ? gq[0] * 10 + gq[1] : -1, 1);

        // lone master, back-to-back
        do_reset();
        delay_mode = 1; shots[0] = 10;
        cycles(40);
        check("lone_dones", done_t.size(), 10);
        check("lone_period", (done_t.size() == 10) ? done_t[9] - done_t[0] : -1, 27);
        check("lone_grants", gq.size(), 10);

        // reset in the middle of an access
        do_reset();
        starve = 1; shots[0] = 1;
        cycles(4); #1;
        check("pre_rst_cmd", o_wrSdram | o_rdSdram, 1);
        rst = 1'b1; req = '0;
        for (int k = 0; k < N; k++) shots[k] = 0;
        cycles(1); #1;
        rst = 1'b0;
        check("rst_gnt", o_gnt, 0);
        check("rst_cmd", {o_wrSdram, o_rdSdram}, 0);
        check("rst_done", o_done, 0);
        clear_logs();
        starve = 0; delay_mode = 1; shots[2] = 1;
        cycles(10);
        check("rst_then_m2", (gq.size() == 1) ? gq[0] : -1, 2);

        // randomised traffic
        do_reset();
        noise = 1; mid_drop = 1; p_raise = 60; delay_mode = 0;
        for (int k = 0; k < N; k++) shots[k] = 1000;
        for (int t = 0; t < 3000; t++) begin
            if (t % 250 == 100) starve = 1;
            cycles(1);
        end
        for (int k = 0; k < N; k++) shots[k] = 0;
        cycles(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
